// File: rtl/stage_monitor.sv
// Watches the sequencer's per-stage release lines and the stages' done pulses.
// Tracks progress, measures per-stage latency and flags order and stall faults.
module stage_monitor #(
    parameter int N_STAGE = 5,
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 200
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_STAGE-1:0] stage_go_n,
    input  logic [N_STAGE-1:0] stage_done,
    output logic [2:0]         cur_stage,
    output logic [N_STAGE-1:0] done_mask,
    output logic               all_done,
    output logic [CNT_W-1:0]   cycle_count,
    output logic [CNT_W-1:0]   last_latency,
    output logic               err_order,
    output logic               err_timeout,
    output logic [2:0]         err_stage
);

    typedef enum logic [2:0] {IDLE, RUN, WAIT_GO, COMPLETE, FAULT} state_t;

    localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT - 1);
    localparam logic [2:0]       LAST   = 3'(N_STAGE - 1);

    state_t             state, state_n;
    logic [2:0]         cur_n, err_stage_n;
    logic [N_STAGE-1:0] mask_n;
    logic [CNT_W-1:0]   cnt_n, lat_n, cnt_inc;
    logic               eo_n, et_n;

    logic [N_STAGE-1:0] cur_bit;
    logic               all_ones, order_bad, done_ok, done_bad, rel, is_last;

    // A stage released while the one below it is still held is an order fault.
    assign order_bad = |(~stage_go_n[N_STAGE-1:1] & stage_go_n[N_STAGE-2:0]);
    assign all_ones  = &stage_go_n;
    assign cur_bit   = N_STAGE'(1) << cur_stage;
    assign done_ok   = |(stage_done & cur_bit);
    assign done_bad  = |(stage_done & ~cur_bit);
    assign rel       = |(~stage_go_n & cur_bit);
    assign is_last   = (cur_stage == LAST);
    assign cnt_inc   = (&cycle_count) ? cycle_count : cycle_count + 1'b1;
    assign all_done  = (state == COMPLETE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cur_stage    <= '0;
            done_mask    <= '0;
            cycle_count  <= '0;
            last_latency <= '0;
            err_order    <= 1'b0;
            err_timeout  <= 1'b0;
            err_stage    <= '0;
        end else begin
            state        <= state_n;
            cur_stage    <= cur_n;
            done_mask    <= mask_n;
            cycle_count  <= cnt_n;
            last_latency <= lat_n;
            err_order    <= eo_n;
            err_timeout  <= et_n;
            err_stage    <= err_stage_n;
        end
    end

    always_comb begin
        state_n     = state;
        cur_n       = cur_stage;
        mask_n      = done_mask;
        cnt_n       = cycle_count;
        lat_n       = last_latency;
        eo_n        = err_order;
        et_n        = err_timeout;
        err_stage_n = err_stage;
        unique case (state)
            IDLE: begin
                if (order_bad) begin
                    state_n     = FAULT;
                    eo_n        = 1'b1;
                    err_stage_n = cur_stage;
                end else if (!stage_go_n[0]) begin
                    state_n = RUN;
                    cur_n   = '0;
                    cnt_n   = '0;
                end
            end
            RUN, WAIT_GO: begin
                if (all_ones) begin
                    state_n = IDLE;
                    cur_n   = '0;
                    mask_n  = '0;
                    cnt_n   = '0;
                end else if (order_bad || done_bad) begin
                    state_n     = FAULT;
                    eo_n        = 1'b1;
                    err_stage_n = cur_stage;
                end else if (state == RUN && done_ok) begin
                    lat_n  = cycle_count;
                    mask_n = done_mask | cur_bit;
                    if (is_last) begin
                        state_n = COMPLETE;
                    end else begin
                        state_n = WAIT_GO;
                        cur_n   = cur_stage + 3'd1;
                        cnt_n   = '0;
                    end
                end else if (state == WAIT_GO && rel) begin
                    state_n = RUN;
                    cnt_n   = '0;
                end else if (cycle_count == TO_LIM) begin
                    state_n     = FAULT;
                    et_n        = 1'b1;
                    err_stage_n = cur_stage;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            COMPLETE: begin
                if (all_ones) begin
                    state_n = IDLE;
                    cur_n   = '0;
                    mask_n  = '0;
                    cnt_n   = '0;
                end else if (order_bad) begin
                    state_n     = FAULT;
                    eo_n        = 1'b1;
                    err_stage_n = cur_stage;
                end
            end
            FAULT: state_n = FAULT;
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_stage_monitor.sv
// Directed bench for stage_monitor: release sequencing, latency capture,
// order and timeout faults, soft restart and asynchronous reset.
module tb_stage_monitor;

    localparam int N = 5;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] stage_go_n = '1;
    logic [N-1:0] stage_done = '0;
    logic [2:0]   cur_stage;
    logic [N-1:0] done_mask;
    logic         all_done;
    logic [W-1:0] cycle_count;
    logic [W-1:0] last_latency;
    logic         err_order;
    logic         err_timeout;
    logic [2:0]   err_stage;

    logic [N-1:0] ones = '1;
    logic [N-1:0] one  = 1;

    int errors = 0;
    int checks = 0;

    stage_monitor #(.N_STAGE(N), .CNT_W(W), .TIMEOUT(200)) dut (
        .clk          (clk),
        .rst          (rst),
        .stage_go_n   (stage_go_n),
        .stage_done   (stage_done),
        .cur_stage    (cur_stage),
        .done_mask    (done_mask),
        .all_done     (all_done),
        .cycle_count  (cycle_count),
        .last_latency (last_latency),
        .err_order    (err_order),
        .err_timeout  (err_timeout),
        .err_stage    (err_stage)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        stage_go_n = '1;
        stage_done = '0;
        step();
        rst = 1'b1;
    endtask

    // Release stage s, hold it in RUN for wait_n cycles, then pulse its done.
    task automatic do_stage(input int s, input int wait_n);
        stage_go_n = ones << (s + 1);
        step();
        chk("rel_cur", 32'(cur_stage), 32'(s));
        chk("rel_cnt", cycle_count, 0);
        repeat (wait_n) step();
        stage_done = one << s;
        step();
        stage_done = '0;
        chk("lat", last_latency, 32'(wait_n));
        chk("mask_bit", 32'(done_mask[s]), 1);
    endtask

    initial begin
        // Reset state and thermometer sequence with latency 4.
        do_reset();
        chk("rst_mask", 32'(done_mask), 0);
        chk("rst_cur", 32'(cur_stage), 0);
        chk("rst_all", 32'(all_done), 0);
        chk("rst_eo", 32'(err_order), 0);
        chk("rst_lat", last_latency, 0);
        for (int s = 0; s < N; s++) begin
            do_stage(s, 4);
            if (s < N - 1) begin
                chk("next_cur", 32'(cur_stage), 32'(s + 1));
                repeat (4) step();
                chk("wait_cnt", cycle_count, 4);
            end
        end
        chk("t1_mask", 32'(done_mask), 32'h1f);
        chk("t1_all", 32'(all_done), 1);
        chk("t1_eo", 32'(err_order), 0);
        chk("t1_et", 32'(err_timeout), 0);
        stage_go_n = '1;
        step();
        chk("rs_all", 32'(all_done), 0);
        chk("rs_mask", 32'(done_mask), 0);
        chk("rs_lat", last_latency, 4);

        // Soft restart while stage 3 is running, done in the same cycle ignored.
        do_stage(0, 4);
        do_stage(1, 5);
        do_stage(2, 6);
        stage_go_n = ones << 4;
        step();
        step();
        stage_go_n = '1;
        stage_done = one << 3;
        step();
        stage_done = '0;
        chk("t5_mask", 32'(done_mask), 0);
        chk("t5_cur", 32'(cur_stage), 0);
        chk("t5_lat", last_latency, 6);
        chk("t5_eo", 32'(err_order), 0);
        for (int s = 0; s < N; s++) do_stage(s, 2);
        chk("t5_all", 32'(all_done), 1);
        chk("t5_lat2", last_latency, 2);

        // Stage 1 released before stage 0 from IDLE.
        do_reset();
        stage_go_n = 5'b11101;
        step();
        chk("t2_eo", 32'(err_order), 1);
        chk("t2_es", 32'(err_stage), 0);
        stage_go_n = '1;
        repeat (3) step();
        chk("t2_hold", 32'(err_order), 1);
        chk("t2_et", 32'(err_timeout), 0);

        // Done from a stage other than the one awaited.
        do_reset();
        stage_go_n = ones << 1;
        step();
        stage_done = one << 3;
        step();
        stage_done = '0;
        chk("xd_eo", 32'(err_order), 1);
        chk("xd_mask", 32'(done_mask), 0);

        // Stage 2 stalls past the timeout.
        do_reset();
        do_stage(0, 1);
        do_stage(1, 1);
        stage_go_n = ones << 3;
        step();
        repeat (199) step();
        chk("t3_cnt", cycle_count, 199);
        chk("t3_pre", 32'(err_timeout), 0);
        step();
        chk("t3_et", 32'(err_timeout), 1);
        chk("t3_es", 32'(err_stage), 2);
        chk("t3_eo", 32'(err_order), 0);
        stage_done = one << 2;
        step();
        stage_done = '0;
        step();
        chk("t3_hold", 32'(err_timeout), 1);
        chk("t3_mask", 32'(done_mask), 3);
        chk("t3_lat", last_latency, 1);
        chk("t3_frz", cycle_count, 199);

        // Done lands on the timeout cycle and wins.
        do_reset();
        do_stage(0, 1);
        do_stage(1, 1);
        do_stage(2, 199);
        chk("t4_et", 32'(err_timeout), 0);
        chk("t4_mask", 32'(done_mask), 7);
        chk("t4_cur", 32'(cur_stage), 3);

        // Asynchronous reset mid-RUN clears outputs before the next edge.
        stage_go_n = ones << 4;
        step();
        step();
        #2 rst = 1'b0;
        #1;
        chk("t6_cur", 32'(cur_stage), 0);
        chk("t6_mask", 32'(done_mask), 0);
        chk("t6_cnt", cycle_count, 0);
        chk("t6_lat", last_latency, 0);
        chk("t6_all", 32'(all_done), 0);
        #2 rst = 1'b1;
        stage_go_n = '1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
